// File: rtl/uart_pixel_rx_if.sv
// uart_pixel_rx_if: pixel output channel of the UART image receiver.
//   rgb_data    {R,G,B} pixel word, DATA_WIDTH bits per channel
//   pixel_valid rgb_data holds a pixel waiting to be accepted
//   out_ready   sink accepts the presented pixel
//   pixel_cnt   index of the presented (or next) pixel within the frame
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
// The receiver connects through the master modport and the pixel sink through
// the slave modport.
interface uart_pixel_rx_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int PIXEL_CNT_WIDTH = 16
);
  logic [3*DATA_WIDTH-1:0]    rgb_data;
  logic                       pixel_valid;
  logic                       out_ready;
  logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt;
  logic                       frame_done;

  modport master (
    output rgb_data, pixel_valid, pixel_cnt, frame_done,
    input  out_ready
  );

  modport slave (
    input  rgb_data, pixel_valid, pixel_cnt, frame_done,
    output out_ready
  );
endinterface

// File: rtl/uart_pixel_rx.sv
// uart_pixel_rx: receives an 8N1 UART byte stream, buffers it in a FIFO,
// locks onto a two-byte frame header and assembles gray / RGB565 / RGB888
// pixels into a {R,G,B} word handed out over a ready/valid channel.
//   clk, reset  system clock, asynchronous active-high reset
//   rx          UART line (asynchronous, idles high)
//   cam_mode    1: camera owns the pipeline, UART bytes are drained and dropped
//   pix_mode    00 gray, 01 RGB565 (high byte first), 10/11 RGB888 (R,G,B)
//   pix_if      pixel channel (rgb_data, pixel_valid, out_ready, pixel_cnt,
//               frame_done)
//   frame_err   sticky: a stop bit was sampled low
//   overflow    sticky: a byte was dropped on a full FIFO
// Both sticky flags clear on reset or when a new frame header is accepted.
module uart_pixel_rx #(
  parameter int                    CLK_FREQ   = 100_000_000,
  parameter int                    BAUD_RATE  = 115_200,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 5,
  parameter int                    IMG_WIDTH  = 176,
  parameter int                    IMG_HEIGHT = 240,
  parameter logic [DATA_WIDTH-1:0] SYNC0      = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] SYNC1      = 8'h55
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            cam_mode,
  input  logic [1:0]      pix_mode,
  uart_pixel_rx_if.master pix_if,
  output logic            frame_err,
  output logic            overflow
);

  localparam int TOTAL_PIXELS    = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIXEL_CNT_WIDTH = $clog2(TOTAL_PIXELS);
  localparam int BAUD_DIV_RAW    = CLK_FREQ / (BAUD_RATE * 16);
  localparam int BAUD_DIV        = (BAUD_DIV_RAW < 1) ? 1 : BAUD_DIV_RAW;
  localparam int BAUD_W          = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int FIFO_ENTRIES    = 1 << FIFO_DEPTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_SYNC0, ST_SYNC1, ST_COLLECT, ST_OUT, ST_DONE} asm_state_t;

  // Bytes making up one pixel in the given format.
  function automatic logic [1:0] bytes_needed(input logic [1:0] mode);
    case (mode)
      2'b00:   return 2'd1;
      2'b01:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Expands the collected bytes (b0 first, b2 the byte just popped) to {R,G,B}.
  // RGB565 widens each field by replicating its top bits into the new LSBs.
  function automatic logic [3*DATA_WIDTH-1:0] expand_pixel(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] b0,
    input logic [DATA_WIDTH-1:0] b1,
    input logic [DATA_WIDTH-1:0] b2
  );
    logic [15:0] w;
    w = 16'({b0, b2});
    case (mode)
      2'b00:   return {b2, b2, b2};
      2'b01:   return (3*DATA_WIDTH)'({w[15:11], w[15:13], w[10:5], w[10:9],
                                       w[4:0], w[4:2]});
      default: return {b0, b1, b2};
    endcase
  endfunction

  // ---------------------------------------------------------------- receiver
  logic                  rx_meta_r, rx_sync_r, rx_prev_r;
  logic [BAUD_W-1:0]     baud_cnt_r;
  logic                  baud_tick_s;
  rx_state_t             rx_state_r, rx_state_next_s;
  logic [3:0]            sample_cnt_r;
  logic [3:0]            bit_cnt_r;
  logic [DATA_WIDTH-1:0] rx_shift_r;
  logic [DATA_WIDTH-1:0] rx_byte_r;
  logic                  rx_valid_r;
  logic                  start_edge_s, mid_start_s, bit_end_s, stop_err_s;

  assign baud_tick_s  = (baud_cnt_r == BAUD_W'(BAUD_DIV - 1));
  assign start_edge_s = rx_prev_r & ~rx_sync_r;
  assign mid_start_s  = baud_tick_s && (sample_cnt_r == 4'd7);
  // Counted from mid start bit, tick 16 lands in the middle of the next bit.
  assign bit_end_s    = baud_tick_s && (sample_cnt_r == 4'd15);
  assign stop_err_s   = (rx_state_r == RX_STOP) && bit_end_s && !rx_sync_r;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // 16x oversampling tick; held in phase with the start edge while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt_r <= '0;
    end else if (rx_state_r == RX_IDLE || baud_tick_s) begin
      baud_cnt_r <= '0;
    end else begin
      baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_r <= RX_IDLE;
    end else begin
      rx_state_r <= rx_state_next_s;
    end
  end

  // Receiver next state.
  always_comb begin
    rx_state_next_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE: begin
        if (start_edge_s) rx_state_next_s = RX_START;
        else              rx_state_next_s = RX_IDLE;
      end
      RX_START: begin
        // A line already high at mid start bit was a glitch.
        if (mid_start_s) rx_state_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
        else             rx_state_next_s = RX_START;
      end
      RX_DATA: begin
        if (bit_end_s && bit_cnt_r == 4'(DATA_WIDTH - 1)) rx_state_next_s = RX_STOP;
        else                                               rx_state_next_s = RX_DATA;
      end
      RX_STOP: begin
        if (bit_end_s) rx_state_next_s = RX_IDLE;
        else           rx_state_next_s = RX_STOP;
      end
      default: rx_state_next_s = RX_IDLE;
    endcase
  end

  // Receiver counters, LSB-first shift register and byte strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt_r <= 4'd0;
      bit_cnt_r    <= 4'd0;
      rx_shift_r   <= '0;
      rx_byte_r    <= '0;
      rx_valid_r   <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          sample_cnt_r <= 4'd0;
          bit_cnt_r    <= 4'd0;
        end
        RX_START: begin
          if (mid_start_s)      sample_cnt_r <= 4'd0;
          else if (baud_tick_s) sample_cnt_r <= sample_cnt_r + 4'd1;
        end
        RX_DATA: begin
          if (baud_tick_s) sample_cnt_r <= sample_cnt_r + 4'd1;
          if (bit_end_s) begin
            rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_WIDTH-1:1]};
            bit_cnt_r  <= bit_cnt_r + 4'd1;
          end
        end
        RX_STOP: begin
          if (baud_tick_s) sample_cnt_r <= sample_cnt_r + 4'd1;
          if (bit_end_s && rx_sync_r) begin
            rx_byte_r  <= rx_shift_r;
            rx_valid_r <= 1'b1;
          end
        end
        default: sample_cnt_r <= 4'd0;
      endcase
    end
  end

  // -------------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] fifo_mem_r [FIFO_ENTRIES];
  logic [FIFO_DEPTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_DEPTH:0]   fifo_cnt_r;
  logic                  fifo_empty_s, fifo_full_s, fifo_push_s, fifo_pop_s, ovf_event_s;
  logic [DATA_WIDTH-1:0] fifo_head_s;

  assign fifo_empty_s = (fifo_cnt_r == '0);
  assign fifo_full_s  = (fifo_cnt_r == (FIFO_DEPTH+1)'(FIFO_ENTRIES));
  assign fifo_head_s  = fifo_mem_r[rd_ptr_r];
  // A full FIFO that is popped in the same cycle still takes the new byte.
  assign fifo_push_s  = rx_valid_r && (!fifo_full_s || fifo_pop_s);
  assign ovf_event_s  = rx_valid_r && fifo_full_s && !fifo_pop_s;

  // FIFO storage; contents are only meaningful below fifo_cnt_r.
  always_ff @(posedge clk) begin
    if (fifo_push_s) fifo_mem_r[wr_ptr_r] <= rx_byte_r;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (fifo_push_s) wr_ptr_r <= wr_ptr_r + FIFO_DEPTH'(1);
      if (fifo_pop_s)  rd_ptr_r <= rd_ptr_r + FIFO_DEPTH'(1);
      case ({fifo_push_s, fifo_pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + (FIFO_DEPTH+1)'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - (FIFO_DEPTH+1)'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // --------------------------------------------------------------- assembler
  asm_state_t                 state_r, state_next_s;
  logic [1:0]                 byte_cnt_r, mode_r;
  logic [DATA_WIDTH-1:0]      b0_r, b1_r;
  logic [3*DATA_WIDTH-1:0]    rgb_r;
  logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt_r;
  logic                       pixel_valid_r, frame_done_r, frame_err_r, overflow_r;
  logic                       sync_ok_s, pix_done_s, collect_s, hs_s;

  // Assembler state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_SYNC0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Assembler next state, FIFO pop and datapath strobes.
  always_comb begin
    state_next_s = state_r;
    fifo_pop_s   = 1'b0;
    sync_ok_s    = 1'b0;
    pix_done_s   = 1'b0;
    collect_s    = 1'b0;
    hs_s         = 1'b0;
    if (cam_mode) begin
      state_next_s = ST_SYNC0;
      fifo_pop_s   = !fifo_empty_s;
    end else begin
      case (state_r)
        ST_SYNC0: begin
          if (!fifo_empty_s) begin
            fifo_pop_s   = 1'b1;
            state_next_s = (fifo_head_s == SYNC0) ? ST_SYNC1 : ST_SYNC0;
          end else begin
            state_next_s = ST_SYNC0;
          end
        end
        ST_SYNC1: begin
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            if (fifo_head_s == SYNC1) begin
              state_next_s = ST_COLLECT;
              sync_ok_s    = 1'b1;
            end else if (fifo_head_s == SYNC0) begin
              state_next_s = ST_SYNC1;
            end else begin
              state_next_s = ST_SYNC0;
            end
          end else begin
            state_next_s = ST_SYNC1;
          end
        end
        ST_COLLECT: begin
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            if (byte_cnt_r == bytes_needed(mode_r) - 2'd1) begin
              state_next_s = ST_OUT;
              pix_done_s   = 1'b1;
            end else begin
              state_next_s = ST_COLLECT;
              collect_s    = 1'b1;
            end
          end else begin
            state_next_s = ST_COLLECT;
          end
        end
        ST_OUT: begin
          if (pix_if.out_ready) begin
            hs_s = 1'b1;
            if (pixel_cnt_r == PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1)) state_next_s = ST_DONE;
            else                                                  state_next_s = ST_COLLECT;
          end else begin
            state_next_s = ST_OUT;
          end
        end
        ST_DONE:  state_next_s = ST_SYNC0;
        default:  state_next_s = ST_SYNC0;
      endcase
    end
  end

  // Pixel datapath, registered outputs and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_r    <= 2'd0;
      mode_r        <= 2'd0;
      b0_r          <= '0;
      b1_r          <= '0;
      rgb_r         <= '0;
      pixel_cnt_r   <= '0;
      pixel_valid_r <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      pixel_valid_r <= (state_next_s == ST_OUT);
      frame_done_r  <= (state_next_s == ST_DONE);
      if (cam_mode) begin
        byte_cnt_r <= 2'd0;
      end else if (sync_ok_s) begin
        byte_cnt_r  <= 2'd0;
        mode_r      <= pix_mode;
        pixel_cnt_r <= '0;
      end else if (pix_done_s) begin
        byte_cnt_r <= 2'd0;
        rgb_r      <= expand_pixel(mode_r, b0_r, b1_r, fifo_head_s);
      end else if (collect_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        if (byte_cnt_r == 2'd0) b0_r <= fifo_head_s;
        else                    b1_r <= fifo_head_s;
      end else if (hs_s) begin
        byte_cnt_r <= 2'd0;
        mode_r     <= pix_mode;
        // The frame's last pixel already reads 0 during the frame_done cycle.
        if (state_next_s == ST_DONE) pixel_cnt_r <= '0;
        else                         pixel_cnt_r <= pixel_cnt_r + PIXEL_CNT_WIDTH'(1);
      end
      // A new event outranks a header clear in the same cycle.
      frame_err_r <= stop_err_s  | (frame_err_r & ~sync_ok_s);
      overflow_r  <= ovf_event_s | (overflow_r  & ~sync_ok_s);
    end
  end

  assign pix_if.rgb_data    = rgb_r;
  assign pix_if.pixel_valid = pixel_valid_r;
  assign pix_if.pixel_cnt   = pixel_cnt_r;
  assign pix_if.frame_done  = frame_done_r;
  assign frame_err          = frame_err_r;
  assign overflow           = overflow_r;

endmodule

// File: tb/tb_uart_pixel_rx.sv
// tb_uart_pixel_rx: directed self-checking bench for uart_pixel_rx with a
// 4x2 image and one baud tick per clock (16 clocks per UART bit).
module tb_uart_pixel_rx;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       cam_mode = 1'b0;
  logic [1:0] pix_mode = 2'b00;
  logic       frame_err, overflow;
  int         n_checks = 0;
  int         n_fail = 0;

  uart_pixel_rx_if #(.DATA_WIDTH(8), .PIXEL_CNT_WIDTH(3)) pix_if ();

  uart_pixel_rx #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .FIFO_DEPTH(5),
    .IMG_WIDTH(4), .IMG_HEIGHT(2)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .cam_mode(cam_mode), .pix_mode(pix_mode),
    .pix_if(pix_if), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame; stop_bit=0 forces a framing error. Starts and ends at negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready_low();
    cam_mode = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic out_ready_low();
    pix_if.out_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 200 && !pix_if.pixel_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 32'(pix_if.pixel_valid), 32'd1);
  endtask

  // Waits for a pixel, checks it, then accepts it with a one-cycle out_ready.
  task automatic accept(input logic [23:0] exp_rgb, input logic [2:0] exp_cnt, input string tag);
    wait_valid(tag);
    check({tag, "_rgb"}, 32'(pix_if.rgb_data), 32'(exp_rgb));
    check({tag, "_cnt"}, 32'(pix_if.pixel_cnt), 32'(exp_cnt));
    pix_if.out_ready = 1'b1;
    @(negedge clk);
    pix_if.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    pix_if.out_ready = 1'b0;
    #1;
    check("reset_outputs", {pix_if.rgb_data, pix_if.pixel_valid, pix_if.pixel_cnt,
                            pix_if.frame_done, frame_err, overflow}, 32'd0);
    do_reset();

    // Gray frame: 8 pixels {n,n,n}, then frame_done with pixel_cnt back to 0.
    pix_mode = 2'b00;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    for (int n = 0; n < 8; n++) send_byte(8'(n), 1'b1);
    for (int n = 0; n < 8; n++) accept({8'(n), 8'(n), 8'(n)}, 3'(n), "gray");
    check("gray_frame_done", 32'(pix_if.frame_done), 32'd1);
    check("gray_cnt_zero", 32'(pix_if.pixel_cnt), 32'd0);
    @(negedge clk);
    check("gray_done_pulse", 32'(pix_if.frame_done), 32'd0);

    // RGB565 expansion.
    do_reset();
    pix_mode = 2'b01;
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
    send_byte(8'hF8, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h07, 1'b1); send_byte(8'hE0, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h1F, 1'b1);
    accept(24'hFF0000, 3'd0, "rgb565_r");
    accept(24'h00FF00, 3'd1, "rgb565_g");
    accept(24'h0000FF, 3'd2, "rgb565_b");

    // RGB888 under 20 cycles of backpressure, accepted once.
    do_reset();
    pix_mode = 2'b10;
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h56, 1'b1);
    wait_valid("bp");
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {7'd0, pix_if.pixel_valid, pix_if.rgb_data}, {8'd1, 24'h123456});
      @(negedge clk);
    end
    accept(24'h123456, 3'd0, "bp_accept");
    check("bp_once", 32'(pix_if.pixel_valid), 32'd0);

    // Sync hunting: 00 and the first AA are discarded.
    do_reset();
    pix_mode = 2'b00;
    send_byte(8'h00, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'h41, 1'b1);
    accept(24'h414141, 3'd0, "hunt");

    // Overflow: 40 bytes behind a stalled pixel; only bytes 1..32 fit. Bytes
    // 31/32 form a header, so a clean resync proves exactly 32 were kept.
    do_reset();
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
    for (int k = 0; k < 40; k++) begin
      if (k < 8)        b = 8'(k);
      else if (k == 31) b = 8'hAA;
      else if (k == 32) b = 8'h55;
      else if (k > 32)  b = 8'h11;
      else              b = 8'h00;
      send_byte(b, 1'b1);
    end
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_no_ferr", 32'(frame_err), 32'd0);
    for (int n = 0; n < 8; n++) accept({8'(n), 8'(n), 8'(n)}, 3'(n), "ovf_px");
    check("ovf_frame_done", 32'(pix_if.frame_done), 32'd1);
    repeat (40) @(negedge clk);
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_no_extra", 32'(pix_if.pixel_valid), 32'd0);
    send_byte(8'h77, 1'b1);
    accept(24'h777777, 3'd0, "ovf_resync");

    // Framing error: bad byte not pushed, flag sticky until a new header.
    do_reset();
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
    send_byte(8'h33, 1'b0);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_no_push", 32'(pix_if.pixel_valid), 32'd0);
    send_byte(8'h44, 1'b1);
    accept(24'h444444, 3'd0, "ferr_next");
    check("ferr_sticky", 32'(frame_err), 32'd1);
    cam_mode = 1'b1;
    repeat (5) @(negedge clk);
    cam_mode = 1'b0;
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    check("ferr_cleared", 32'(frame_err), 32'd0);

    // Camera mode mid-pixel: partial pixel dropped, UART bytes drained.
    do_reset();
    pix_mode = 2'b10;
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h12, 1'b1);
    cam_mode = 1'b1;
    send_byte(8'h34, 1'b1); send_byte(8'h56, 1'b1);
    check("cam_no_valid", 32'(pix_if.pixel_valid), 32'd0);
    cam_mode = 1'b0;
    pix_mode = 2'b00;
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h99, 1'b1);
    accept(24'h999999, 3'd0, "cam_resume");

    // Reset mid-frame: outputs clear at once, headerless data is ignored.
    do_reset();
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    accept(24'h010101, 3'd0, "rst_px0");
    wait_valid("rst_px1");
    reset = 1'b1;
    #1;
    check("rst_outputs", {pix_if.rgb_data, pix_if.pixel_valid, pix_if.pixel_cnt,
                          pix_if.frame_done, frame_err, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    repeat (30) @(negedge clk);
    check("rst_no_pixel", 32'(pix_if.pixel_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
